// File: rtl/multi_busarb_pkg.sv
// Shared definitions for the N-master bus arbiter: strobe polarities,
// default bus widths, arbiter state encoding and a width helper.
package multi_busarb_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH     = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Ceiling log2, never below 1 so that it can size a vector directly.
  function automatic int clog2(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/multi_busarb_rr_pick.sv
// Rotating priority picker: first set request at or after `start`, wrapping.
// With start fixed at 0 it degenerates to a plain lowest-index priority encoder.
module multi_busarb_rr_pick
  import multi_busarb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant
);

  logic [W-1:0] scan_idx [N];
  logic [N-1:0] scan_req;

  // scan_idx[k] is the master visited k-th; start is always below N, so one
  // conditional subtraction performs the modulo for any N.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_scan
    logic [W:0] sum;
    assign sum          = {1'b0, start} + (W + 1)'(gi);
    assign scan_idx[gi] = (sum >= (W + 1)'(N)) ? W'(sum - (W + 1)'(N)) : sum[W-1:0];
    assign scan_req[gi] = req[scan_idx[gi]];
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid && scan_req[k]) begin
        valid             = 1'b1;
        idx               = scan_idx[k];
        grant[scan_idx[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_busarb.sv
// N-master shared-bus arbiter with fixed or round-robin priority, optional
// tenure limit, and the owner-steered address/data/strobe multiplexer.
module multi_busarb
  import multi_busarb_pkg::*;
#(
  parameter int NMASTER  = 4,
  parameter int ADDR_W   = BUS_ADDR_WIDTH,
  parameter int DATA_W   = DATA_WIDTH,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NMASTER-1:0]          breq_,
  output logic [NMASTER-1:0]          bgrt_,
  input  logic [NMASTER*ADDR_W-1:0]   m_addr,
  input  logic [NMASTER*DATA_W-1:0]   m_wdata,
  input  logic [NMASTER-1:0]          m_rw_,
  output logic [ADDR_W-1:0]           addr,
  output logic [DATA_W-1:0]           idata,
  output logic                        rw_,
  output logic [clog2(NMASTER)-1:0]   owner,
  output logic                        busy
);

  localparam int OWN_W  = clog2(NMASTER);
  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD);
  localparam logic [OWN_W-1:0]  LAST_IDX  = OWN_W'(NMASTER - 1);
  localparam bit                UNLIMITED = (MAX_HOLD == 0);
  localparam bit                ROUND_ROBIN = (RR_MODE != 0);

  arb_state_t          state_reg;
  logic [NMASTER-1:0]  grant_n_reg;
  logic [OWN_W-1:0]    owner_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic                busy_reg;

  logic [NMASTER-1:0]  req;
  logic [NMASTER-1:0]  owner_mask;
  logic [NMASTER-1:0]  pick_req;
  logic [NMASTER-1:0]  pick_grant;
  logic [OWN_W-1:0]    pick_start;
  logic [OWN_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                owner_req;
  logic                keep;

  assign req        = ~breq_;
  assign owner_mask = NMASTER'(1) << owner_reg;
  assign owner_req  = |(req & owner_mask);

  // While owned, the picker only ever sees the other masters, so both a
  // release and a forced handover land on a different master.
  assign pick_req   = (state_reg == ST_OWNED) ? (req & ~owner_mask) : req;
  assign pick_start = !ROUND_ROBIN           ? '0 :
                      (owner_reg == LAST_IDX) ? '0 : owner_reg + OWN_W'(1);

  multi_busarb_rr_pick #(
    .N (NMASTER),
    .W (OWN_W)
  ) u_rr_pick (
    .req   (pick_req),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx),
    .grant (pick_grant)
  );

  // In OWNED, pick_valid means some other master is waiting.
  assign keep = owner_req && (UNLIMITED || (hold_reg != HOLD_LIM) || !pick_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      grant_n_reg <= '1;
      owner_reg   <= '0;
      hold_reg    <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            state_reg   <= ST_OWNED;
            grant_n_reg <= ~pick_grant;
            owner_reg   <= pick_idx;
            hold_reg    <= '0;
            busy_reg    <= 1'b1;
          end
        end
        ST_OWNED: begin
          if (keep) begin
            if (!UNLIMITED && (hold_reg != HOLD_LIM)) begin
              hold_reg <= hold_reg + HOLD_W'(1);
            end
          end else if (pick_valid) begin
            grant_n_reg <= ~pick_grant;
            owner_reg   <= pick_idx;
            hold_reg    <= '0;
          end else begin
            state_reg   <= ST_IDLE;
            grant_n_reg <= '1;
            hold_reg    <= '0;
            busy_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          grant_n_reg <= '1;
          hold_reg    <= '0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  logic [ADDR_W-1:0] addr_arr  [NMASTER];
  logic [DATA_W-1:0] wdata_arr [NMASTER];

  genvar gi;
  for (gi = 0; gi < NMASTER; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
  end

  // Without a grant the device bus is parked so no master can strobe devices.
  always_comb begin
    addr  = '0;
    idata = '0;
    rw_   = DISABLE_;
    if (busy_reg) begin
      addr  = addr_arr[owner_reg];
      idata = wdata_arr[owner_reg];
      rw_   = m_rw_[owner_reg];
    end
  end

  assign bgrt_ = grant_n_reg;
  assign owner = owner_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_multi_busarb.sv
// Bench for multi_busarb: a round-robin/limited and a fixed/unlimited instance
// share stimulus and are each compared with a behavioural arbitration model.
module tb_multi_busarb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    breq_ = '1;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_rw_;

  logic [N-1:0]  bgrt_rr, bgrt_fx;
  logic [AW-1:0] addr_rr, addr_fx;
  logic [DW-1:0] idata_rr, idata_fx;
  logic          rw_rr, rw_fx;
  logic [1:0]    owner_rr, owner_fx;
  logic          busy_rr, busy_fx;

  multi_busarb #(.NMASTER(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_HOLD(8)) dut_rr (
    .clk(clk), .reset(reset), .breq_(breq_), .bgrt_(bgrt_rr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rw_(m_rw_), .addr(addr_rr), .idata(idata_rr), .rw_(rw_rr),
    .owner(owner_rr), .busy(busy_rr)
  );

  multi_busarb #(.NMASTER(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_HOLD(0)) dut_fx (
    .clk(clk), .reset(reset), .breq_(breq_), .bgrt_(bgrt_fx), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rw_(m_rw_), .addr(addr_fx), .idata(idata_fx), .rw_(rw_fx),
    .owner(owner_fx), .busy(busy_fx)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model index 0 mirrors dut_rr, index 1 mirrors dut_fx.
  int mdl_rr  [2] = '{1, 0};
  int mdl_max [2] = '{8, 0};
  bit mdl_busy  [2];
  int mdl_owner [2];
  int mdl_hold  [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mdl_busy[d]  = 1'b0;
      mdl_owner[d] = 0;
      mdl_hold[d]  = 0;
    end
  endtask

  function automatic int pick(input int d, input logic [N-1:0] cand);
    if (mdl_rr[d] != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (cand[(mdl_owner[d] + k) % N]) return (mdl_owner[d] + k) % N;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (cand[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic [N-1:0] br);
    logic [N-1:0] req;
    logic [N-1:0] others;
    int w;
    req = ~br;
    if (!mdl_busy[d]) begin
      w = pick(d, req);
      if (w >= 0) begin
        mdl_busy[d]  = 1'b1;
        mdl_owner[d] = w;
        mdl_hold[d]  = 0;
      end
    end else begin
      others = req;
      others[mdl_owner[d]] = 1'b0;
      if (req[mdl_owner[d]] && (mdl_max[d] == 0 || mdl_hold[d] < mdl_max[d] || others == 0)) begin
        if (mdl_hold[d] < mdl_max[d]) mdl_hold[d]++;
      end else begin
        w = pick(d, others);
        if (w >= 0) begin
          mdl_owner[d] = w;
          mdl_hold[d]  = 0;
        end else begin
          mdl_busy[d] = 1'b0;
          mdl_hold[d] = 0;
        end
      end
    end
  endtask

  task automatic check_dut(input string name, input int d, input logic [N-1:0] g,
                           input logic [1:0] o, input logic b, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic r);
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          er;
    eg = '1;
    ea = '0;
    ed = '0;
    er = 1'b1;
    if (mdl_busy[d]) begin
      eg[mdl_owner[d]] = 1'b0;
      ea = m_addr[mdl_owner[d]*AW +: AW];
      ed = m_wdata[mdl_owner[d]*DW +: DW];
      er = m_rw_[mdl_owner[d]];
    end
    check({name, ".bgrt_"}, 64'(g), 64'(eg));
    check({name, ".owner"}, 64'(o), 64'(mdl_owner[d]));
    check({name, ".busy"},  64'(b), 64'(mdl_busy[d]));
    check({name, ".addr"},  64'(a), 64'(ea));
    check({name, ".idata"}, 64'(wd), 64'(ed));
    check({name, ".rw_"},   64'(r), 64'(er));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      model_step(0, breq_);
      model_step(1, breq_);
    end
    #1;
    check_dut("rr", 0, bgrt_rr, owner_rr, busy_rr, addr_rr, idata_rr, rw_rr);
    check_dut("fx", 1, bgrt_fx, owner_fx, busy_fx, addr_fx, idata_fx, rw_fx);
  endtask

  task automatic randomize_data();
    m_addr  = {$urandom, $urandom};
    m_wdata = {$urandom, $urandom, $urandom, $urandom};
    m_rw_   = N'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    randomize_data();
    m_rw_ = '1;
    reset = 1'b1;
    breq_ = '1;

    // Reset values.
    step();
    check("rst.bgrt_", 64'(bgrt_rr), 64'hF);
    check("rst.busy",  64'(busy_rr), 64'h0);
    check("rst.rw_",   64'(rw_rr),   64'h1);
    #2 reset = 1'b0;

    // Single request from master 2.
    breq_ = 4'b1011;
    step();
    check("single.bgrt_", 64'(bgrt_rr), 64'hB);
    check("single.owner", 64'(owner_rr), 64'd2);
    check("single.addr",  64'(addr_rr), 64'(m_addr[2*AW +: AW]));
    step();

    // Asynchronous reset in the middle of master 2's tenure.
    reset = 1'b1;
    #1;
    model_reset();
    check("areset.bgrt_", 64'(bgrt_rr), 64'hF);
    check("areset.rw_",   64'(rw_rr),   64'h1);
    check("areset.busy",  64'(busy_rr), 64'h0);
    check("areset.fx_bgrt_", 64'(bgrt_fx), 64'hF);
    #1 reset = 1'b0;
    step();
    breq_ = '1;
    step();
    check("release.bgrt_", 64'(bgrt_rr), 64'hF);

    // Idle isolation while every master drives an access strobe.
    m_rw_ = '0;
    step();
    check("idle.rw_",   64'(rw_rr),    64'h1);
    check("idle.addr",  64'(addr_rr),  64'h0);
    check("idle.idata", 64'(idata_fx), 64'h0);
    m_rw_ = '1;

    // Fixed priority: masters 1 and 3 together, then master 1 releases.
    breq_ = 4'b0101;
    step();
    check("fixed.first", 64'(owner_fx), 64'd1);
    breq_ = 4'b0111;
    step();
    check("fixed.handover", 64'(owner_fx), 64'd3);
    check("fixed.no_idle",  64'(busy_fx),  64'h1);
    breq_ = '1;
    step();

    // Round-robin fairness with all four requesting: 9-cycle tenures 1,2,3,0,1.
    do_reset();
    breq_ = '0;
    for (int c = 0; c < 45; c++) begin
      step();
      check($sformatf("rr_seq[%0d]", c), 64'(owner_rr), 64'((1 + c / 9) % N));
      check($sformatf("fx_keep[%0d]", c), 64'(owner_fx), 64'd0);
    end
    breq_ = '1;
    step();

    // Unlimited hold: master 0 keeps the bus while master 1 waits.
    do_reset();
    breq_ = 4'b1100;
    for (int c = 0; c < 100; c++) begin
      step();
      check($sformatf("unlim[%0d]", c), 64'(owner_fx), 64'd0);
    end
    breq_ = 4'b1101;
    step();
    check("unlim.next_owner", 64'(owner_fx), 64'd1);
    check("unlim.next_bgrt_", 64'(bgrt_fx), 64'hD);
    breq_ = '1;
    step();

    // Random traffic with persistent requests and random datapath values.
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(3) == 0) breq_[m] = ~breq_[m];
      end
      randomize_data();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_busarb.md
# multi_busarb

Parametrised N-master shared-bus arbiter and multiplexer. It generalises the two-CPU arbitration and address/data/rw_ steering to NMASTER requesters with selectable fixed or round-robin priority and an optional tenure limit. It drives the single device-side bus, with an explicit idle state in which no master is selected. It sits between the mips32 cores and the devices block; device read data stays broadcast to all masters outside this block.

## Interface
- NMASTER, 4, number of masters (2..8)
- ADDR_W, 16, bus address width (instantiate with `BUS_ADDR_WIDTH)
- DATA_W, 32, bus data width (instantiate with `DATA_WIDTH)
- RR_MODE, 1, 1 = round-robin priority, 0 = fixed priority (index 0 highest)
- MAX_HOLD, 8, maximum tenure in cycles while others are waiting; 0 = unlimited

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- breq_  in  NMASTER  per-master bus request, active-low (`Enable_ = 0)
- bgrt_  out  NMASTER  per-master grant, active-low, one-hot-low or all-high
- m_addr  in  NMASTER*ADDR_W  master addresses, master i at bits [i*ADDR_W +: ADDR_W]
- m_wdata  in  NMASTER*DATA_W  master write data, same packing
- m_rw_  in  NMASTER  master access strobe, active-low (`Enable_ = access)
- addr  out  ADDR_W  device-side address
- idata  out  DATA_W  device-side write data
- rw_  out  1  device-side access strobe, active-low
- owner  out  clog2(NMASTER)  index of granted master (last owner when idle)
- busy  out  1  high while any grant is active

## Operation
- State: IDLE (no grant) and OWNED (exactly one bgrt_ low). Registers: grant vector, owner index, hold counter, busy.
- At every clk edge, the next owner is computed from current breq_:
  - IDLE, no requests: stay IDLE.
  - IDLE, requests present: grant the winner and enter OWNED.
  - OWNED, owner still requesting, and either the hold counter is below MAX_HOLD or no other master is requesting: keep the grant and increment the hold counter, saturating.
  - OWNED, owner released: hand over directly to the winner among the other requesters, with no idle cycle, or go to IDLE if none.
  - OWNED, owner still requesting, hold counter equals MAX_HOLD (nonzero), another master is requesting: forced handover to the winner among the others. The preempted master keeps bgrt_ high until it wins again.
- Winner selection:
  - RR_MODE=1: first requester scanning from (owner+1) mod NMASTER upward, wrapping.
  - RR_MODE=0: lowest index requester, with the current owner excluded on forced handover.
- The hold counter resets to 0 on every new grant, including handover.
- Datapath (combinational from registered grant):
  - OWNED: addr/idata/rw_ = m_addr/m_wdata/m_rw_ of the owner.
  - IDLE: addr = 0, idata = 0, rw_ = `Disable_ (1). No master can strobe devices without a grant.
- Masters must hold requests until granted. A request deasserted before grant is simply dropped.

## Timing
- Reset values: bgrt_ all 1, owner 0, busy 0, rw_ 1, addr 0, idata 0, hold counter 0, state IDLE. Round-robin scan starts at master 1 after reset; with only master 0 requesting, master 0 still wins.
- Grant latency: breq_ low sampled at edge k gives bgrt_ low after edge k; datapath switches in the same cycle.
- Release latency: breq_ high sampled at edge k gives bgrt_ high after edge k. The next owner's grant appears at the same edge.
- Simultaneous requests from idle: single winner per the priority rule, never two grants.
- Reset asserted mid-tenure: all outputs return to reset values immediately (asynchronous); the master must re-request.
- NMASTER=2, RR_MODE=0, MAX_HOLD=0 reproduces legacy two-CPU behaviour, except that idle rw_ is 1.

## Structure
- Shared package/define file: `Enable_/`Disable_, width defines, clog2 function.
- One sub-module: rr_pick (request vector plus start index gives one-hot winner and valid). It is instantiated once and also serves fixed mode with start index 0.
- Top wrapper replaces its per-CPU ternary muxes with one multi_busarb (NMASTER=2).

## Test plan
- Reset: assert reset mid-grant of master 2 -> bgrt_=4'b1111, rw_=1, busy=0 within the same cycle.
- Single request: breq_=4'b1011 -> next edge bgrt_=4'b1011, owner=2, addr=m_addr[2]. Release -> bgrt_=4'b1111 next edge.
- RR fairness: all four requesting continuously with MAX_HOLD=8 -> grants 1,2,3,0,1 in order, each held exactly 9 cycles (counter values 0..8).
- Fixed priority: RR_MODE=0, masters 1 and 3 request together from idle -> master 1 granted. Master 1 releases -> master 3 granted at the same edge, no idle cycle.
- Unlimited hold: MAX_HOLD=0, master 0 requests for 100 cycles while master 1 waits -> master 0 keeps the grant; master 1 is granted the edge after master 0 releases.
- Idle isolation: no requests while m_rw_ are all 0 -> rw_=1, addr=0, idata=0.
